// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, converter states and width helper
package bcd_pkg;

    localparam int BCD_DIG_W = 4;
    localparam int BCD_MAX   = 9;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        DONE = 2'b10
    } bcd_state_t;

    // Smallest binary width that holds 10^digits-1; valid for digits up to 18.
    function automatic int min_out_w(input int digits);
        longint unsigned max_val;
        int w;
        max_val = 1;
        w = 0;
        for (int i = 0; i < digits; i++) begin
            max_val = max_val * 10;
        end
        max_val = max_val - 1;
        for (int b = 0; b < 64; b++) begin
            if ((max_val >> b) != 0) begin
                w = b + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// rtl/bcd2bin_seq_if.sv - input/output valid-ready bundle of the BCD converter
interface bcd2bin_seq_if #(
    parameter int DIGITS = 8,
    parameter int OUT_W  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_bin;
    logic                  out_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );
endinterface

// File: rtl/bcd_digit_mac.sv
// rtl/bcd_digit_mac.sv - one decimal step: acc*10 + digit, with invalid-digit flag
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic [OUT_W-1:0]     acc,
    input  logic [BCD_DIG_W-1:0] digit,
    output logic [OUT_W-1:0]     acc_next,
    output logic                 digit_bad
);

    // Shift-add keeps the x10 off a real multiplier.
    assign acc_next  = (acc << 3) + (acc << 1) + OUT_W'(digit);
    assign digit_bad = (digit > BCD_DIG_W'(BCD_MAX));

endmodule

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential packed-BCD to binary converter, one digit per clock
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int OUT_W  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd2bin_seq_if.slave  bus
);

    localparam int SR_W  = BCD_DIG_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < 1 || DIGITS > 9) begin : g_bad_digits
        $error("bcd2bin_seq: DIGITS must be in 1..9");
    end
    if (OUT_W < min_out_w(DIGITS)) begin : g_bad_out_w
        $error("bcd2bin_seq: OUT_W too small for DIGITS");
    end

    bcd_state_t         state;
    logic [SR_W-1:0]    sr;
    logic [OUT_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               err;

    logic [OUT_W-1:0]   acc_next;
    logic               digit_bad;
    logic               err_next;

    bcd_digit_mac #(
        .OUT_W (OUT_W)
    ) u_mac (
        .acc       (acc),
        .digit     (sr[SR_W-1 -: BCD_DIG_W]),
        .acc_next  (acc_next),
        .digit_bad (digit_bad)
    );

    assign err_next = err | digit_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sr            <= '0;
            acc           <= '0;
            cnt           <= '0;
            err           <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_bin   <= '0;
            bus.out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        sr           <= bus.in_bcd;
                        acc          <= '0;
                        cnt          <= '0;
                        err          <= 1'b0;
                        bus.in_ready <= 1'b0;
                        state        <= CONV;
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    err <= err_next;
                    sr  <= sr << BCD_DIG_W;
                    cnt <= cnt + 1'b1;
                    // Bad digits still run the full count so latency never depends on data.
                    if (cnt == CNT_W'(DIGITS - 1)) begin
                        bus.out_valid <= 1'b1;
                        bus.out_err   <= err_next;
                        bus.out_bin   <= err_next ? '0 : acc_next;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
Sequential packed-BCD to binary converter; the inverse of the team's binary-to-decimal display digit splitter. It turns multi-digit decimal input (switch, keypad or debug-console values) into a binary operand for the RV32I datapath, e.g. data-memory preload or a register-file poke. It converts one digit per clock, most-significant digit first, using an acc*10+digit multiply-accumulate. Valid/ready handshakes sit on both sides.

Parameters:
DIGITS, 8, number of packed BCD digits on in_bcd (1..9)
OUT_W, 32, binary result width; must satisfy 2^OUT_W > 10^DIGITS-1 (elaboration-time check)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_bcd holds a value to convert
in_ready  output  1  converter can accept a value
in_bcd  input  4*DIGITS  packed BCD, digit DIGITS-1 in the MS nibble
out_valid  output  1  out_bin/out_err hold a result
out_ready  input  1  consumer accepts the result
out_bin  output  OUT_W  binary result; 0 when out_err=1
out_err  output  1  at least one nibble of the accepted value was >9

Behaviour:
- Reset (async assert, sync deassert by the top level): state=IDLE; in_ready=1; out_valid=0; out_bin=0; out_err=0; acc=0; cnt=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: latch in_bcd into shift register sr; acc=0; cnt=0; err=0; go to CONV.
  - CONV: in_ready=0. Each cycle:
    - d = sr[MS nibble]; acc <= acc*10 + d (computed as (acc<<3)+(acc<<1)+d, OUT_W bits).
    - err <= err | (d>9); sr <<= 4; cnt++.
    - When cnt==DIGITS-1, go to DONE after this update.
  - DONE: out_valid=1; out_bin=err?0:acc; out_err=err. Outputs stay stable until out_valid&&out_ready, then go to IDLE with out_valid=0.
- Latency: a handshake in cycle c gives out_valid first high in cycle c+DIGITS+1, regardless of digit values or errors.
- Throughput: one conversion per DIGITS+2 cycles at most. in_ready is low in CONV and DONE; no accept in the same cycle as output handoff.
- Invalid digits (0xA-0xF) do not shorten the conversion: full latency, out_bin forced to 0, out_err=1.
- in_bcd changing after the accepting edge has no effect (it is latched).
- in_valid held high in CONV/DONE is ignored. The held value is accepted on the first IDLE cycle.
- out_ready high while out_valid=0 is ignored.
- Reset mid-CONV or mid-DONE aborts the conversion; the result is discarded and no out_valid pulse is produced.
- No overflow can occur, given the OUT_W constraint.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_DIG_W=4 and BCD_MAX=9.
  - State enum {IDLE, CONV, DONE}, encoded 2'b00/01/10.
  - A function for the minimum OUT_W given DIGITS.
- One sub-module, bcd_digit_mac: combinational acc_next = acc*10+d plus digit-invalid flag, parameterised by OUT_W. It is reusable by a future keypad-entry accumulator.

Test Plan:
- DIGITS=8, reset released, in_bcd=32'h0000_0042 pulsed with in_valid, out_ready=1 -> out_valid high exactly 9 cycles after accept cycle, out_bin=42, out_err=0, in_ready back to 1 the cycle after.
- in_bcd=32'h9999_9999 -> out_bin=32'h05F5_E0FF (99999999), out_err=0; in_bcd=0 -> out_bin=0.
- in_bcd=32'h123A_0005 -> out_err=1, out_bin=0, latency still 9 cycles.
- out_ready held 0 for 5 cycles after out_valid -> out_bin/out_err/out_valid stable, in_ready=0 throughout; second in_valid with 32'h0000_0100 accepted only after release, result 100.
- Back-to-back in_valid held high with 32'h0001_2345 then 32'h0000_0007 -> results 12345 then 7 in order, each after a separate accept.
- rst_n pulsed low in the 4th CONV cycle -> outputs return to reset values asynchronously, no out_valid. A subsequent conversion of 32'h0000_0010 yields 10.
